// File: rtl/gpio_pin_bridge.sv
// Board-pin <-> core-GPIO bridge: per-pin synchroniser, debouncer and change events on
// inputs; minimum-visible-time pulse stretching on outputs.
module gpio_pin_bridge #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned GPIO_W      = 8,
  parameter int unsigned PINS_PER_CH = 2,
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned STRETCH     = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CH*PINS_PER_CH-1:0] pin_in,
  output logic [NUM_CH*GPIO_W-1:0]      gpio_in,
  output logic [NUM_CH-1:0]             edge_event,
  input  logic [NUM_CH*GPIO_W-1:0]      gpio_out,
  output logic [NUM_CH*PINS_PER_CH-1:0] pin_out
);

  localparam int unsigned NP    = NUM_CH * PINS_PER_CH;
  localparam int unsigned CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int unsigned HC_W  = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;

  logic [NP-1:0]     sync1, sync2;
  logic [NP-1:0]     st, st_nxt;
  logic [CNT_W-1:0]  cnt [NP];
  logic [CNT_W-1:0]  cnt_nxt [NP];
  logic [NUM_CH-1:0] ev_nxt;
  logic [NP-1:0]     src, pout_nxt;
  logic [HC_W-1:0]   hc [NP];
  logic [HC_W-1:0]   hc_nxt [NP];

  // Core GPIO bits at or above PINS_PER_CH have no board pin behind them.
  logic unused_gpio_out;
  assign unused_gpio_out = ^gpio_out;

  // Debounce: accept a new level after DEBOUNCE consecutive differing sync2 samples.
  always_comb begin
    st_nxt = st;
    ev_nxt = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      cnt_nxt[p] = '0;
      if (DEBOUNCE == 0) begin
        st_nxt[p] = sync2[p];
      end else if (sync2[p] != st[p]) begin
        if (cnt[p] == CNT_W'(DEBOUNCE - 1)) st_nxt[p] = sync2[p];
        else                                cnt_nxt[p] = cnt[p] + CNT_W'(1);
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++)
      ev_nxt[c] = |(st_nxt[c*PINS_PER_CH +: PINS_PER_CH] ^ st[c*PINS_PER_CH +: PINS_PER_CH]);
  end

  // Channel mapping between flattened core buses and pin vectors.
  always_comb begin
    gpio_in = '0;
    src     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned i = 0; i < PINS_PER_CH; i++) begin
        gpio_in[c*GPIO_W + i]   = st[c*PINS_PER_CH + i];
        src[c*PINS_PER_CH + i]  = gpio_out[c*GPIO_W + i];
      end
    end
  end

  // Stretch: a new level is taken only when no hold is running; toggles during hold are lost.
  always_comb begin
    pout_nxt = pin_out;
    for (int unsigned q = 0; q < NP; q++) begin
      hc_nxt[q] = hc[q];
      if (STRETCH == 0) begin
        pout_nxt[q] = src[q];
        hc_nxt[q]   = '0;
      end else if (hc[q] == '0) begin
        if (src[q] != pin_out[q]) begin
          pout_nxt[q] = src[q];
          hc_nxt[q]   = HC_W'(STRETCH);
        end
      end else begin
        hc_nxt[q] = hc[q] - HC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      st         <= '0;
      edge_event <= '0;
      pin_out    <= '0;
      for (int unsigned p = 0; p < NP; p++) begin
        cnt[p] <= '0;
        hc[p]  <= '0;
      end
    end else begin
      sync1      <= pin_in;
      sync2      <= sync1;
      st         <= st_nxt;
      edge_event <= ev_nxt;
      pin_out    <= pout_nxt;
      for (int unsigned p = 0; p < NP; p++) begin
        cnt[p] <= cnt_nxt[p];
        hc[p]  <= hc_nxt[p];
      end
    end
  end

endmodule

// File: tb/tb_gpio_pin_bridge.sv
// Self-checking bench for gpio_pin_bridge: default instance plus a STRETCH=7 instance,
// compared each cycle against a window/time based reference model.
module tb_gpio_pin_bridge;

  localparam int unsigned NCH = 4;
  localparam int unsigned GW  = 8;
  localparam int unsigned PPC = 2;
  localparam int unsigned NP  = NCH * PPC;
  localparam int unsigned DB  = 16;
  localparam int unsigned ST  = 7;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     pin_in;
  logic [NCH*GW-1:0] gpio_out;
  logic [NCH*GW-1:0] gpio_in, gpio_in_s;
  logic [NCH-1:0]    edge_event, edge_event_s;
  logic [NP-1:0]     pin_out, pin_out_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_pin_bridge dut (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .gpio_in(gpio_in),
    .edge_event(edge_event), .gpio_out(gpio_out), .pin_out(pin_out)
  );

  gpio_pin_bridge #(.STRETCH(ST)) dut_s (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .gpio_in(gpio_in_s),
    .edge_event(edge_event_s), .gpio_out(gpio_out), .pin_out(pin_out_s)
  );

  // Reference model state
  logic [NP-1:0]  m_s1, m_s2, m_st;
  logic [NP-1:0]  win [$];
  logic [NCH-1:0] m_ev;
  logic [NP-1:0]  m_po0, m_po7;
  int             last_chg [NP];
  int             k = 0;

  function automatic logic [NCH*GW-1:0] expand(input logic [NP-1:0] v);
    logic [NCH*GW-1:0] r = '0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < PPC; i++) r[c*GW + i] = v[c*PPC + i];
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_st = '0; m_ev = '0; m_po0 = '0; m_po7 = '0;
    win.delete();
    for (int q = 0; q < NP; q++) last_chg[q] = -1000;
  endtask

  // A pin's accepted level flips once the last DB synchronised samples all disagree with it;
  // an output pin may change only when more than ST edges have passed since its last change.
  task automatic model_step();
    logic [NP-1:0] new_st;
    logic [NP-1:0] srcv;
    bit            all_diff;
    k++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    win.push_back(m_s2);
    if (win.size() > DB) void'(win.pop_front());
    new_st = m_st;
    if (win.size() == DB) begin
      for (int p = 0; p < NP; p++) begin
        all_diff = 1'b1;
        foreach (win[j]) if (win[j][p] == m_st[p]) all_diff = 1'b0;
        if (all_diff) new_st[p] = ~m_st[p];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      m_ev[c] = 1'b0;
      for (int i = 0; i < PPC; i++) if (new_st[c*PPC+i] != m_st[c*PPC+i]) m_ev[c] = 1'b1;
    end
    m_st = new_st;
    m_s2 = m_s1;
    m_s1 = pin_in;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < PPC; i++) srcv[c*PPC + i] = gpio_out[c*GW + i];
    m_po0 = srcv;
    for (int q = 0; q < NP; q++) begin
      if ((k - last_chg[q]) > int'(ST) && srcv[q] != m_po7[q]) begin
        m_po7[q]    = srcv[q];
        last_chg[q] = k;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("gpio_in", gpio_in, expand(m_st));
    check("edge_event", 32'(edge_event), 32'(m_ev));
    check("pin_out_s0", 32'(pin_out), 32'(m_po0));
    check("pin_out_s7", 32'(pin_out_s), 32'(m_po7));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic settle(input logic [NP-1:0] v);
    pin_in = v;
    repeat (24) tick();
  endtask

  int  lat;
  logic [NCH-1:0] ev_at_rise;
  bit  saw_hi, saw_ev;
  int  hi_cnt;
  int  idx;

  initial begin
    // 1: reset with all pins high, then release
    reset_n = 1'b0; pin_in = '1; gpio_out = '0;
    model_reset();
    #2;
    check("rst_gpio_in", gpio_in, 32'h0);
    check("rst_pin_out", 32'(pin_out), 32'h0);
    check("rst_edge", 32'(edge_event), 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 17) check("t1_before", gpio_in, 32'h0);
      if (i == 18) begin
        check("t1_gpio_in", gpio_in, 32'h03030303);
        check("t1_edge", 32'(edge_event), 32'hF);
      end
    end
    tick();
    check("t1_edge_once", 32'(edge_event), 32'h0);

    // 2: debounce latency of a clean step on pin 0
    settle('0);
    pin_in[0] = 1'b1;
    lat = 0; ev_at_rise = '0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (lat == 0 && gpio_in[0]) begin
        lat = i;
        ev_at_rise = edge_event;
      end
    end
    check("t2_latency", 32'(lat), 32'd18);
    check("t2_edge", 32'(ev_at_rise), 32'h1);

    // 3: 15-cycle glitch rejected, 16-cycle pulse accepted
    saw_hi = 0; saw_ev = 0;
    pin_in[5] = 1'b1;
    repeat (15) tick();
    pin_in[5] = 1'b0;
    repeat (25) begin
      tick();
      if (gpio_in[17]) saw_hi = 1;
      if (edge_event[2]) saw_ev = 1;
    end
    check("t3_glitch_level", 32'(saw_hi), 32'd0);
    check("t3_glitch_edge", 32'(saw_ev), 32'd0);
    pin_in[5] = 1'b1;
    repeat (16) tick();
    pin_in[5] = 1'b0;
    repeat (25) begin
      tick();
      if (gpio_in[17]) saw_hi = 1;
      if (edge_event[2]) saw_ev = 1;
    end
    check("t3_accept_level", 32'(saw_hi), 32'd1);
    check("t3_accept_edge", 32'(saw_ev), 32'd1);

    // 4: stretch of a 1-cycle pulse, second pulse during hold dropped
    hi_cnt = 0;
    gpio_out[8] = 1'b1;
    tick();
    check("t4_track", 32'(pin_out[2]), 32'd1);
    if (pin_out_s[2]) hi_cnt++;
    gpio_out[8] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 2) gpio_out[8] = 1'b1;
      if (i == 3) gpio_out[8] = 1'b0;
      tick();
      if (pin_out_s[2]) hi_cnt++;
    end
    check("t4_stretch_width", 32'(hi_cnt), 32'd8);

    // 5: bits above the pin count are ignored
    gpio_out = 32'hFCFCFCFC;
    repeat (10) tick();
    check("t5_pin_out0", 32'(pin_out), 32'h0);
    check("t5_pin_out7", 32'(pin_out_s), 32'h0);
    check("t5_upper_in", gpio_in & 32'hFCFCFCFC, 32'h0);

    // random phase: slow pin toggling and random core outputs
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        idx = int'($urandom_range(0, NP - 1));
        pin_in[idx] = ~pin_in[idx];
      end
      if ($urandom_range(0, 5) == 0) gpio_out = $urandom();
      tick();
    end

    // 6: async reset mid-debounce and mid-hold
    gpio_out = '0;
    settle(8'h0F);
    pin_in = 8'hFF;
    repeat (8) tick();
    gpio_out[8] = 1'b1;
    tick();
    gpio_out[8] = 1'b0;
    repeat (2) tick();
    check("t6_pre_gpio_in", gpio_in, 32'h00000303);
    check("t6_pre_hold", 32'(pin_out_s[2]), 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_gpio_in", gpio_in, 32'h0);
    check("t6_rst_pin_out", 32'(pin_out_s), 32'h0);
    check("t6_rst_edge", 32'(edge_event), 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 17) check("t6_not_early", gpio_in, 32'h0);
      if (i == 18) check("t6_full_latency", gpio_in, 32'h03030303);
    end
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
